branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- EX-stage consumer of the fetch predictor's output and producer of its training inputs.
- Carries each fetched instruction's predicted next-PC from IF down to EX, then computes the actual next-PC.
- Drives BRANCH, BRANCH_TAKEN, BRANCH_ADDR, RETURN, PREDICTED and FLUSH back to the predictor and pipeline, plus a redirect address.
- Sequences multi-cycle squash of younger instructions after a mispredict.

Parameters:
- ADDR_WIDTH, 32, PC/address width.
- PIPE_DEPTH, 2, instruction-advance cycles from IF to EX (length of prediction pipeline, >=1).
- FLUSH_CYCLES, 2, advance cycles (including the detect cycle) during which younger EX instructions are squashed (>=1).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- CACHE_READY  in  1  pipeline advance qualifier.
- CACHE_READY_DATA  in  1  pipeline advance qualifier.
- IF_VALID  in  1  instruction fetched this cycle.
- IF_PRD_ADDR  in  ADDR_WIDTH  predictor's next-PC for the fetched instruction.
- EX_VALID  in  1  valid instruction in EX.
- EX_PC  in  ADDR_WIDTH  PC of EX instruction.
- EX_IS_BRANCH  in  1  conditional branch.
- EX_IS_JUMP  in  1  unconditional jump (jal/jalr).
- EX_IS_RETURN  in  1  return-type jump.
- EX_COND_TRUE  in  1  branch condition outcome.
- EX_TARGET  in  ADDR_WIDTH  resolved target.
- BRANCH  out  1  predictor-update strobe.
- BRANCH_TAKEN  out  1  control transfer taken.
- BRANCH_ADDR  out  ADDR_WIDTH  resolved target.
- RETURN  out  1  instruction is a return.
- PREDICTED  out  1  prediction was correct.
- FLUSH  out  1  mispredict; kill younger instructions.
- REDIRECT_ADDR  out  ADDR_WIDTH  correct next-PC.
- BRANCH_COUNT  out  32  resolved control transfers.
- MISPRED_COUNT  out  32  mispredicts.

Behaviour:
- advance = CACHE_READY & CACHE_READY_DATA. All registers update only when advance=1 (RST excepted); stall holds every register.
- Prediction pipeline: PIPE_DEPTH entries of {valid, pred_addr}.
  - On advance: entry0 <= {IF_VALID & ~squash_in, IF_PRD_ADDR}; entry[k] <= entry[k-1].
  - Tail entry is EX's prediction.
- squash = (state==FLUSHING). ex_live = EX_VALID & ~squash.
- actual_next = ((EX_IS_BRANCH & EX_COND_TRUE) | EX_IS_JUMP) ? EX_TARGET : EX_PC+4, modulo 2^ADDR_WIDTH.
- Combinational outputs (same cycle as EX inputs, no latency):
  - BRANCH = ex_live & (EX_IS_BRANCH | EX_IS_JUMP).
  - BRANCH_TAKEN = BRANCH & (EX_IS_JUMP | EX_COND_TRUE).
  - BRANCH_ADDR = EX_TARGET.
  - RETURN = ex_live & EX_IS_RETURN.
  - PREDICTED = ~ex_live | (tail.valid & tail.pred_addr == actual_next). Non-branches are checked too, so an aliased predictor hit is caught.
  - FLUSH = ex_live & ~PREDICTED.
  - REDIRECT_ADDR = actual_next.
- FSM states RUN, FLUSHING; flush counter is $clog2(FLUSH_CYCLES+1) bits.
  - RUN, advance & FLUSH: all pipeline entries invalidated; if FLUSH_CYCLES>1 go FLUSHING with cnt=FLUSH_CYCLES-1, else stay RUN.
  - FLUSHING, advance: cnt--; at cnt==1 return to RUN. EX instructions are squashed (no BRANCH/FLUSH); pipeline entries written as invalid (squash_in=squash).
  - A mispredict cannot be raised while FLUSHING.
- EX_VALID with invalid tail entry (e.g. first instruction after reset/flush, predictor bypassed): PREDICTED=0 and FLUSH=1, unless squashed.
- Stall with FLUSH high: FLUSH and outputs stay asserted; FSM transitions only when advance=1.
- RST (any state, including mid-flush): entries invalid, state RUN, cnt 0, counters 0. Outputs reset to BRANCH=0, BRANCH_TAKEN=0, RETURN=0, FLUSH=0, PREDICTED=1 given EX_VALID=0; BRANCH_ADDR/REDIRECT_ADDR follow inputs.

Optional Feature:
- BRANCH_RESOLVER_STATS_EN defined:
  - BRANCH_COUNT += BRANCH on advance.
  - MISPRED_COUNT += FLUSH on advance.
  - Both wrap at 2^32 and are zeroed by RST.
- Undefined: both outputs tied to 0 and no counter flops are built.

Decomposition:
- Package branch_pkg: state enum {RUN, FLUSHING}, INSN_BYTES=4, pred-entry struct {valid, pred_addr}.
- One sub-module: pred_pipe, the PIPE_DEPTH shift register with advance enable and synchronous invalidate-all.

Test Plan:
- Reset, then 4 sequential non-branch instructions with IF_PRD_ADDR=PC+4 (PC 0x100..0x10C) -> PREDICTED=1, FLUSH=0 throughout, BRANCH=0.
- Taken branch EX_PC=0x200, EX_TARGET=0x240, EX_COND_TRUE=1, predicted 0x240 -> BRANCH=1, BRANCH_TAKEN=1, PREDICTED=1, FLUSH=0.
- Same branch predicted 0x204 -> FLUSH=1, REDIRECT_ADDR=0x240. Next FLUSH_CYCLES-1 advance cycles: EX_VALID=1 ignored (BRANCH=0, FLUSH=0). MISPRED_COUNT=1 with STATS_EN.
- Not-taken branch EX_PC=0x300 predicted 0x380 -> FLUSH=1, REDIRECT_ADDR=0x304, BRANCH_TAKEN=0.
- Mispredict with CACHE_READY=0 for 3 cycles -> FLUSH held high, pipeline and FSM frozen. Flush sequence begins on first advance.
- Assert RST during FLUSHING -> next cycle state RUN, counters 0. First EX instruction with invalid tail yields FLUSH=1, REDIRECT_ADDR=EX_PC+4.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch resolver.
// Contents: FSM state enum, instruction size, and the prediction pipeline
// entry {valid, pred_addr}. The entry address field is sized for the widest
// supported PC (PRED_ADDR_MAX). Narrower PCs are zero-extended into it, and
// the constant upper bits drop out in synthesis.
package branch_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        FLUSHING = 1'b1
    } br_state_e;

    localparam int INSN_BYTES    = 4;
    localparam int PRED_ADDR_MAX = 64;

    typedef struct packed {
        logic                     valid;
        logic [PRED_ADDR_MAX-1:0] pred_addr;
    } pred_entry_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Bus bundle between the pipeline/predictor (master) and branch_resolver (slave).
// The master drives the advance qualifiers, the IF prediction, and the EX
// instruction description.
// The slave returns the predictor training strobes, the flush/redirect, and
// the statistics counters.
interface branch_resolver_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  CACHE_READY;
    logic                  CACHE_READY_DATA;
    logic                  IF_VALID;
    logic [ADDR_WIDTH-1:0] IF_PRD_ADDR;
    logic                  EX_VALID;
    logic [ADDR_WIDTH-1:0] EX_PC;
    logic                  EX_IS_BRANCH;
    logic                  EX_IS_JUMP;
    logic                  EX_IS_RETURN;
    logic                  EX_COND_TRUE;
    logic [ADDR_WIDTH-1:0] EX_TARGET;

    logic                  BRANCH;
    logic                  BRANCH_TAKEN;
    logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
    logic                  RETURN;
    logic                  PREDICTED;
    logic                  FLUSH;
    logic [ADDR_WIDTH-1:0] REDIRECT_ADDR;
    logic [31:0]           BRANCH_COUNT;
    logic [31:0]           MISPRED_COUNT;

    modport master (
        output CACHE_READY, CACHE_READY_DATA, IF_VALID, IF_PRD_ADDR,
               EX_VALID, EX_PC, EX_IS_BRANCH, EX_IS_JUMP, EX_IS_RETURN,
               EX_COND_TRUE, EX_TARGET,
        input  BRANCH, BRANCH_TAKEN, BRANCH_ADDR, RETURN, PREDICTED, FLUSH,
               REDIRECT_ADDR, BRANCH_COUNT, MISPRED_COUNT
    );

    modport slave (
        input  CACHE_READY, CACHE_READY_DATA, IF_VALID, IF_PRD_ADDR,
               EX_VALID, EX_PC, EX_IS_BRANCH, EX_IS_JUMP, EX_IS_RETURN,
               EX_COND_TRUE, EX_TARGET,
        output BRANCH, BRANCH_TAKEN, BRANCH_ADDR, RETURN, PREDICTED, FLUSH,
               REDIRECT_ADDR, BRANCH_COUNT, MISPRED_COUNT
    );
endinterface

// File: rtl/branch_resolver_pred_pipe.sv
// pred_pipe: carries each fetched instruction's predicted next-PC from IF to EX.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (all entries invalid)
//   adv       - shift enable; without it every entry holds
//   inv_all   - with adv, clear every valid bit, including the one being loaded
//   din       - entry loaded at the head
//   tail      - oldest entry, i.e. the prediction for the EX instruction
module pred_pipe
    import branch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        inv_all,
    input  pred_entry_t din,
    output pred_entry_t tail
);

    pred_entry_t [DEPTH-1:0] ent_q, ent_d;

    always_comb begin
        ent_d = ent_q;
        if (adv) begin
            ent_d[0] = din;
            for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
            if (inv_all) begin
                for (int k = 0; k < DEPTH; k++) ent_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ent_q <= '0;
        else     ent_q <= ent_d;
    end

    assign tail = ent_q[DEPTH-1];

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: EX-stage next-PC check and predictor training.
// This block compares the prediction carried from IF against the resolved
// next-PC. It drives the predictor update strobes and flush/redirect.
// After a mispredict, it squashes younger EX instructions for FLUSH_CYCLES
// advance cycles, counting the detect cycle.
// Ports:
//   CLK, RST - clock, synchronous active-high reset
//   bus      - branch_resolver_if.slave (IF/EX inputs, resolver outputs)
// Optional: define BRANCH_RESOLVER_STATS_EN to build the BRANCH_COUNT and
// MISPRED_COUNT counters. Otherwise both outputs are tied to zero.
// ADDR_WIDTH must not exceed branch_pkg::PRED_ADDR_MAX.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int PIPE_DEPTH   = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    branch_resolver_if.slave bus
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    br_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                  advance;
    logic                  squash;
    logic                  ex_live;
    logic [ADDR_WIDTH-1:0] actual_next;
    pred_entry_t           head, tail;

    logic branch, taken, ret, predicted, flush;

    assign advance = bus.CACHE_READY & bus.CACHE_READY_DATA;

    assign actual_next = ((bus.EX_IS_BRANCH & bus.EX_COND_TRUE) | bus.EX_IS_JUMP)
                       ? bus.EX_TARGET
                       : bus.EX_PC + ADDR_WIDTH'(INSN_BYTES);

    // Fetches issued during the squash window are discarded at the head.
    assign head.valid     = bus.IF_VALID & ~squash;
    assign head.pred_addr = PRED_ADDR_MAX'(bus.IF_PRD_ADDR);

    // Invalidate-all only takes effect on a flushing advance, which is
    // exactly when the redirect is consumed.
    pred_pipe #(.DEPTH(PIPE_DEPTH)) u_pred_pipe (
        .clk     (CLK),
        .rst     (RST),
        .adv     (advance),
        .inv_all (flush),
        .din     (head),
        .tail    (tail)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state. flush is never raised while FLUSHING, so the only way
    // out of FLUSHING is the countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (advance && flush && FLUSH_CYCLES > 1) begin
                    state_d = FLUSHING;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSHING: begin
                if (advance) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        squash    = (state_q == FLUSHING);
        ex_live   = bus.EX_VALID & ~squash;
        branch    = ex_live & (bus.EX_IS_BRANCH | bus.EX_IS_JUMP);
        taken     = branch & (bus.EX_IS_JUMP | bus.EX_COND_TRUE);
        ret       = ex_live & bus.EX_IS_RETURN;
        // Non-branches are checked as well, so an aliased predictor hit on
        // straight-line code is caught. An empty tail always mispredicts.
        predicted = ~ex_live |
                    (tail.valid & (tail.pred_addr == PRED_ADDR_MAX'(actual_next)));
        flush     = ex_live & ~predicted;
    end

    assign bus.BRANCH        = branch;
    assign bus.BRANCH_TAKEN  = taken;
    assign bus.BRANCH_ADDR   = bus.EX_TARGET;
    assign bus.RETURN        = ret;
    assign bus.PREDICTED     = predicted;
    assign bus.FLUSH         = flush;
    assign bus.REDIRECT_ADDR = actual_next;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (advance) begin
            br_cnt_d = br_cnt_q + 32'(branch);
            mp_cnt_d = mp_cnt_q + 32'(flush);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign bus.BRANCH_COUNT  = br_cnt_q;
    assign bus.MISPRED_COUNT = mp_cnt_q;
`else
    assign bus.BRANCH_COUNT  = '0;
    assign bus.MISPRED_COUNT = '0;
`endif

endmodule
